// File: rtl/xnor_serial_cmp.sv
// Bit-serial equality comparator: one shared g_XNOR gate walks two WIDTH-bit
// operands LSB first and reports word equality plus the first mismatching bit.
module xnor_serial_cmp #(
    parameter int WIDTH      = 16,
    parameter int EARLY_EXIT = 1,
    parameter int IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic [IW-1:0]    mismatch_idx
);

    // One-hot so that each handshake output is a single state flop.
    localparam logic [2:0] S_IDLE  = 3'b001;
    localparam logic [2:0] S_SHIFT = 3'b010;
    localparam logic [2:0] S_DONE  = 3'b100;

    localparam logic [IW-1:0] CNT_LAST = IW'(WIDTH - 1);
    localparam logic          EARLY_EN = (EARLY_EXIT != 0) ? 1'b1 : 1'b0;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [IW-1:0]    r_cnt;
    logic [IW-1:0]    r_midx;
    logic             r_acc;
    logic             r_first;
    logic             r_eq;
    logic [IW-1:0]    r_idx;
    logic             w_x;
    logic             w_last;
    logic             w_exit;

    g_XNOR u_xnor (
        .i_a (r_sa[0]),
        .i_b (r_sb[0]),
        .o_y (w_x)
    );

    assign w_last = (r_cnt == CNT_LAST);
    assign w_exit = w_last | (EARLY_EN & ~w_x);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_exit) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_SHIFT;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            S_IDLE:  ready = 1'b1;
            S_SHIFT: busy  = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Operand shifting, accumulation and result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_midx  <= '0;
            r_acc   <= 1'b1;
            r_first <= 1'b0;
            r_eq    <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_cnt   <= '0;
                        r_midx  <= '0;
                        r_acc   <= 1'b1;
                        r_first <= 1'b0;
                        r_eq    <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_acc <= r_acc & w_x;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    if (!w_x && !r_first) begin
                        r_midx  <= r_cnt;
                        r_first <= 1'b1;
                    end
                    // Counter parks on the last index instead of wrapping.
                    if (!w_last) begin
                        r_cnt <= r_cnt + IW'(1);
                    end
                    if (w_exit) begin
                        r_eq <= r_acc & w_x;
                        if (r_first) begin
                            r_idx <= r_midx;
                        end else if (!w_x) begin
                            r_idx <= r_cnt;
                        end else begin
                            r_idx <= '0;
                        end
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign eq           = r_eq;
    assign mismatch_idx = r_idx;

endmodule

// Structural two-input XNOR cell shared by the serial comparator.
module g_XNOR (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a ^ i_b);
endmodule

// File: tb/tb_xnor_serial_cmp.sv
// Self-checking bench: 16-bit comparators with and without early exit share
// stimulus; a 1-bit instance covers the single-bit corner.
module tb_xnor_serial_cmp;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        start1 = 1'b0;
    logic [0:0]  a1 = 1'b0;
    logic [0:0]  b1 = 1'b0;

    logic       ready_e, busy_e, done_e, eq_e;
    logic [3:0] idx_e;
    logic       ready_f, busy_f, done_f, eq_f;
    logic [3:0] idx_f;
    logic       ready_1, busy_1, done_1, eq_1;
    logic [0:0] idx_1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xnor_serial_cmp #(.WIDTH(16), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .ready(ready_e), .busy(busy_e), .done(done_e), .eq(eq_e), .mismatch_idx(idx_e));

    xnor_serial_cmp #(.WIDTH(16), .EARLY_EXIT(0)) dut_f (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .ready(ready_f), .busy(busy_f), .done(done_f), .eq(eq_f), .mismatch_idx(idx_f));

    xnor_serial_cmp #(.WIDTH(1), .EARLY_EXIT(1)) dut_1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1),
        .ready(ready_1), .busy(busy_1), .done(done_1), .eq(eq_1), .mismatch_idx(idx_1));

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        veq;
        int          vidx;
        int          vlat_e;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: equality, lowest differing bit, and cycle of the done pulse.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb,
                         output logic meq, output int midx, output int mlat);
        meq  = (ma == mb);
        midx = 0;
        for (int i = 15; i >= 0; i--) begin
            if (ma[i] != mb[i]) midx = i;
        end
        mlat = meq ? 16 : midx + 1;
    endtask

    // Start a compare on both 16-bit DUTs and check latency/results.
    // inject > 0 pulses a competing start sampled at edge T+inject.
    task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic xeq, input int xidx, input int xlat_e, input int inject);
        int de = 0, df = 0, ne = 0, nf = 0;
        int se_eq = 0, se_idx = 0, sf_eq = 0, sf_idx = 0;
        int re = 0, rf = 0;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v;
        @(posedge clk); #1;
        start = 1'b0; a = ~ta; b = ta;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start = (inject > 0 && k == inject - 1) ? 1'b1 : 1'b0;
            if (k == 1) begin
                chk({tag, " busy_f@1"}, int'(busy_f), 1);
                chk({tag, " ready_f@1"}, int'(ready_f), 0);
            end
            if (done_e) begin
                ne++;
                if (de == 0) begin de = k; se_eq = int'(eq_e); se_idx = int'(idx_e); end
            end
            if (done_f) begin
                nf++;
                if (df == 0) begin df = k; sf_eq = int'(eq_f); sf_idx = int'(idx_f); end
            end
            if (de != 0 && k == de + 1) re = int'(ready_e);
            if (df != 0 && k == df + 1) rf = int'(ready_f);
        end
        start = 1'b0;
        chk({tag, " lat_early"}, de, xlat_e);
        chk({tag, " eq_early"}, se_eq, int'(xeq));
        chk({tag, " idx_early"}, se_idx, xidx);
        chk({tag, " ready_early"}, re, 1);
        chk({tag, " pulses_early"}, ne, 1);
        chk({tag, " lat_full"}, df, 16);
        chk({tag, " eq_full"}, sf_eq, int'(xeq));
        chk({tag, " idx_full"}, sf_idx, xidx);
        chk({tag, " ready_full"}, rf, 1);
        chk({tag, " pulses_full"}, nf, 1);
        chk({tag, " eq_held"}, int'(eq_f), int'(xeq));
        chk({tag, " idx_held"}, int'(idx_f), xidx);
    endtask

    task automatic run1(input string tag, input logic ta, input logic tb_v, input logic xeq);
        int d = 0, s_eq = 0, s_idx = 0, r = 0;
        @(negedge clk);
        start1 = 1'b1; a1 = ta; b1 = tb_v;
        @(posedge clk); #1;
        start1 = 1'b0; a1 = ~ta;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (done_1 && d == 0) begin d = k; s_eq = int'(eq_1); s_idx = int'(idx_1); end
            if (d != 0 && k == d + 1) r = int'(ready_1);
        end
        chk({tag, " lat"}, d, 1);
        chk({tag, " eq"}, s_eq, int'(xeq));
        chk({tag, " idx"}, s_idx, 0);
        chk({tag, " ready"}, r, 1);
    endtask

    initial begin
        logic        meq;
        int          midx, mlat, nd;
        logic [15:0] ra, rb;

        vecs[0] = '{16'hA5A5, 16'hA5A5, 1'b1, 0, 16};
        vecs[1] = '{16'h0000, 16'h0100, 1'b0, 8, 9};
        vecs[2] = '{16'hFFFF, 16'h7FFE, 1'b0, 0, 1};
        vecs[3] = '{16'h0000, 16'h8000, 1'b0, 15, 16};
        vecs[4] = '{16'h1234, 16'h1230, 1'b0, 2, 3};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 0, 16};

        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", int'(ready_e), 1);
        chk("rst busy", int'(busy_e), 0);
        chk("rst done", int'(done_f), 0);
        chk("rst eq", int'(eq_f), 0);
        chk("rst idx", int'(idx_f), 0);
        chk("rst ready1", int'(ready_1), 1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run16($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
                  vecs[i].veq, vecs[i].vidx, vecs[i].vlat_e, 0);
        end

        // Competing start during a busy scan must be ignored.
        run16("ignored_start", 16'hA5A5, 16'hA5A5, 1'b1, 0, 16, 3);

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                default: rb = ra ^ 16'($urandom);
            endcase
            model(ra, rb, meq, midx, mlat);
            run16($sformatf("rnd%0d", i), ra, rb, meq, midx, mlat, 0);
        end

        // Asynchronous reset in the middle of a scan.
        @(negedge clk);
        start = 1'b1; a = 16'h0F0F; b = 16'h0F0F;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst busy", int'(busy_f), 1);
        reset_n = 1'b0;
        #1;
        chk("async busy", int'(busy_f), 0);
        chk("async ready", int'(ready_f), 1);
        chk("async busy_e", int'(busy_e), 0);
        chk("async eq", int'(eq_f), 0);
        chk("async idx", int'(idx_f), 0);
        @(negedge clk);
        reset_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done_e || done_f) nd++;
        end
        chk("no_done_after_abort", nd, 0);
        run16("post_rst", 16'hC3C3, 16'hC3C7, 1'b0, 2, 3, 0);

        run1("w1_ne", 1'b1, 1'b0, 1'b0);
        run1("w1_eq", 1'b1, 1'b1, 1'b1);
        run1("w1_eq0", 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xnor_serial_cmp.md
Name: xnor_serial_cmp

Overview:
Bit-serial equality comparator controller. It time-shares one structural g_XNOR gate instance across two WIDTH-bit operands, one bit per clock, LSB first. It accumulates the word-equal result and the index of the first mismatching bit. It sits beside the structural gate library as the sequencer for a single shared XNOR resource, with a start/ready/done handshake toward the requester.

Parameters:
WIDTH, 16, operand width in bits; legal range is 1 or more.
EARLY_EXIT, 1, 1 = stop at the first mismatching bit; 0 = always scan all WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
ready  output  1  high in IDLE; start is accepted only when ready=1
busy  output  1  high while in state SHIFT
done  output  1  one-cycle pulse in state DONE
eq  output  1  1 = operands equal; held until the next accepted start
mismatch_idx  output  IW  index of the first mismatching bit (0 if eq=1); held until the next accepted start; IW = max(1, clog2(WIDTH))

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, eq=0, mismatch_idx=0, shift regs=0, bit counter=0, accumulator=1. Reset asserted mid-SHIFT aborts the compare immediately; no done pulse is produced.
- Exactly one g_XNOR instance. Its inputs are the LSBs of the A/B shift registers; its output is x.
- States: IDLE, SHIFT, DONE. Outputs are decoded from the state register: ready=(IDLE), busy=(SHIFT), done=(DONE).
- IDLE, at an edge with start=1:
  - load sa<=a, sb<=b, cnt<=0, acc<=1, first_found<=0;
  - clear eq<=0 and mismatch_idx<=0;
  - go to SHIFT. With start=0, remain in IDLE.
- SHIFT, at each edge (bit under test = cnt):
  - acc<=acc & x;
  - if x=0 and first_found=0: record midx<=cnt and set first_found<=1;
  - shift sa and sb right by 1;
  - cnt<=cnt+1.
- SHIFT exits to DONE at the edge where either condition holds:
  - cnt=WIDTH-1 (last bit evaluated), or
  - EARLY_EXIT=1 and x=0.
- Outputs written on that exit edge:
  - eq<=acc&x;
  - mismatch_idx<=midx, or cnt when this bit is the first mismatch, or 0 if equal.
- DONE: done=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- Latency, with the start accepted at edge T:
  - full scan: DONE entered at edge T+WIDTH; ready returns at edge T+WIDTH+1;
  - early exit at first mismatch i: DONE entered at edge T+i+1.
- start while busy or in DONE: ignored, no queuing. Operand changes after capture have no effect.
- Back-to-back: start held high in the IDLE cycle after DONE is accepted normally. Minimum request period is WIDTH+2 cycles for a full scan.
- cnt never wraps. At WIDTH=1, SHIFT lasts exactly one edge.

Test Plan:
- WIDTH=16, a=b=16'hA5A5, start at edge T -> busy for 16 cycles; done pulses after edge T+16; eq=1, mismatch_idx=0; ready=1 after edge T+17.
- EARLY_EXIT=1, a=16'h0000, b=16'h0100 -> done after edge T+9; eq=0, mismatch_idx=8.
- EARLY_EXIT=0, same operands -> done after edge T+16; eq=0, mismatch_idx=8. Multiple mismatches a=16'hFFFF, b=16'h7FFE -> mismatch_idx=0.
- start pulsed at T+3 during busy with different operands -> ignored; result matches the first request. eq and mismatch_idx stay stable while idle until the next accepted start.
- reset_n low at T+5 mid-scan -> outputs go to reset values immediately (asynchronously); no done pulse; a new start after release completes normally.
- WIDTH=1: a=1, b=0 -> done after edge T+1, eq=0, mismatch_idx=0; a=b=1 -> eq=1.
